// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: issues imem reads, holds on icache misses, applies
// redirects (deferring them across an outstanding miss) and freezes on halt.
module fetch_sequencer #(
  parameter logic [31:0] PC_INIT = 32'h00000000,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             stall,
  input  logic             redirect_en,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic             imemREN,
  output logic [31:0]      imemaddr,
  output logic             instr_valid,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pend_pc, pend_pc_next;
  logic [31:0] redir_aligned;

  assign redir_aligned = redirect_pc & ~32'd3;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= FETCH;
      pc          <= PC_INIT;
      pend_pc     <= '0;
      fetch_count <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pend_pc <= pend_pc_next;
      if (instr_valid && (fetch_count != '1))
        fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pend_pc_next = pend_pc;
    unique case (state)
      FETCH: begin
        if (halt) begin
          state_next = HALTED;
        end else if (redirect_en) begin
          // A redirect during a miss must wait for the miss to drain.
          if (ihit) begin
            pc_next = redir_aligned;
          end else begin
            pend_pc_next = redir_aligned;
            state_next   = PEND;
          end
        end else if (ihit && !stall) begin
          pc_next = pc + 32'd4;
        end
      end
      PEND: begin
        if (halt) begin
          state_next = HALTED;
        end else if (ihit) begin
          pc_next    = redirect_en ? redir_aligned : pend_pc;
          state_next = FETCH;
        end else if (redirect_en) begin
          pend_pc_next = redir_aligned;
        end
      end
      HALTED: ;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    imemREN     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    imemaddr    = PC_INIT;
    if (!RST) begin
      imemaddr    = pc;
      imemREN     = (state != HALTED);
      halted      = (state == HALTED);
      instr_valid = (state == FETCH) && !halt && !redirect_en && ihit && !stall;
    end
  end

  assign pc_plus4 = imemaddr + 32'd4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer, checked against a
// behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam logic [31:0] PC_INIT = 32'h00000000;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST, ihit, stall, redirect_en, halt;
  logic [31:0]      redirect_pc;
  logic             imemREN, instr_valid, halted;
  logic [31:0]      imemaddr, pc_plus4;
  logic [CNT_W-1:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  // Model: current PC, whether a redirect is waiting behind a miss, halt flag.
  logic [31:0] m_pc, m_target;
  bit          m_waiting, m_frozen;
  int unsigned m_cnt;

  fetch_sequencer #(.PC_INIT(PC_INIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .instr_valid(instr_valid),
    .pc_plus4(pc_plus4), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs against the model, then advance.
  task automatic step(input bit r, input bit ih, input bit st, input bit re,
                      input logic [31:0] rp, input bit h);
    bit          accept;
    logic [31:0] tgt;
    RST = r; ihit = ih; stall = st; redirect_en = re; redirect_pc = rp; halt = h;
    #1;
    tgt    = {rp[31:2], 2'b00};
    accept = !r && !m_frozen && !m_waiting && !h && !re && ih && !st;
    chk("imemaddr", imemaddr, r ? PC_INIT : m_pc);
    chk("pc_plus4", pc_plus4, (r ? PC_INIT : m_pc) + 32'd4);
    chk("imemREN", {31'd0, imemREN}, {31'd0, !r && !m_frozen});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, accept});
    chk("fetch_count", {28'd0, fetch_count}, m_cnt);
    if (!r) chk("halted", {31'd0, halted}, {31'd0, m_frozen});
    if (r) begin
      m_pc = PC_INIT; m_waiting = 0; m_frozen = 0; m_cnt = 0;
    end else if (!m_frozen) begin
      if (h) m_frozen = 1;
      else if (m_waiting && ih) begin
        m_pc = re ? tgt : m_target;
        m_waiting = 0;
      end else if (m_waiting || (re && !ih)) begin
        if (re) m_target = tgt;
        m_waiting = 1;
      end else if (re) m_pc = tgt;
      else if (accept) begin
        m_pc = m_pc + 32'd4;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1; ihit = 0; stall = 0; redirect_en = 0; redirect_pc = '0; halt = 0;
    m_pc = PC_INIT; m_target = '0; m_waiting = 0; m_frozen = 0; m_cnt = 0;
    @(posedge CLK);
    #1;
    step(1, 1, 0, 1, 32'h55, 0);

    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imemaddr, 32'(i * 4));
      step(0, 1, 0, 0, 0, 0);
    end
    chk("seq_count", {28'd0, fetch_count}, 32'd4);

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    chk("miss_hold", imemaddr, 32'h10);
    step(0, 1, 0, 0, 0, 0);
    chk("miss_done", imemaddr, 32'h14);

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("stall_hold", imemaddr, 32'h20);
    step(0, 1, 0, 0, 0, 0);
    chk("stall_done", imemaddr, 32'h24);
    chk("stall_count", {28'd0, fetch_count}, 32'd9);

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 32'h103, 0);
    chk("redirect", imemaddr, 32'h100);
    chk("redirect_count", {28'd0, fetch_count}, 32'd12);

    step(0, 1, 0, 1, 32'h40, 0);
    step(0, 0, 0, 1, 32'h200, 0);
    step(0, 0, 0, 1, 32'h300, 0);
    chk("pend_hold", imemaddr, 32'h40);
    step(0, 1, 0, 0, 0, 0);
    chk("pend_done", imemaddr, 32'h300);

    step(0, 1, 0, 1, 32'hFFFF_FFFE, 0);
    chk("wrap_pc", imemaddr, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    chk("wrap_addr", imemaddr, 32'h0);
    step(0, 1, 0, 1, 32'h500, 1);
    for (int i = 0; i < 5; i++) begin
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_addr", imemaddr, 32'h0);
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
    end
    step(1, 1, 0, 0, 0, 0);
    chk("rst_addr", imemaddr, PC_INIT);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_count", {28'd0, fetch_count}, 32'd0);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 70, $urandom_range(99) < 25,
           $urandom_range(99) < 15, $urandom, $urandom_range(199) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch-stage controller that owns and sequences the program counter feeding instruction memory. It issues imem reads at the current PC and holds on instruction-cache misses (ihit low). It advances by 4 or redirects to a branch/jump target, squashing the wrong-path fetch, and freezes on halt. It sits between the PC register path, the icache port and the decode latch, and exports a retired-fetch counter for perf/debug.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset; must be word-aligned.
CNT_W, 32, width of fetch_count; counter saturates at all-ones.

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  synchronous, active-high reset
ihit  input  1  icache returns valid instruction for imemaddr this cycle
stall  input  1  decode cannot accept an instruction this cycle
redirect_en  input  1  control-flow change resolved downstream this cycle
redirect_pc  input  32  target PC; bits [1:0] ignored and forced to 0
halt  input  1  halt instruction committed
imemREN  output  1  instruction read enable
imemaddr  output  32  current fetch PC
instr_valid  output  1  fetched instruction accepted by decode this cycle
pc_plus4  output  32  imemaddr + 4, for link-register writes
halted  output  1  sequencer frozen
fetch_count  output  CNT_W  number of cycles with instr_valid=1, saturating

Behaviour:
- Reset (RST high at edge): pc=PC_INIT, state=FETCH, pend_pc=0, fetch_count=0, halted=0. While RST is high, outputs are forced: imemREN=0, instr_valid=0, imemaddr=PC_INIT.
- States: FETCH, PEND (redirect latched during a miss), HALTED.
- imemaddr = pc in all states. pc_plus4 = pc+4 modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- imemREN = 1 in FETCH and PEND; 0 in HALTED.
- FETCH transitions, in priority order:
  - halt: go to HALTED; pc holds.
  - redirect_en: pc <= {redirect_pc[31:2],2'b00}; instr_valid=0, because the instruction fetched this cycle is wrong-path. This applies regardless of ihit and stall. If ihit=0, the outstanding miss must still complete, so latch pend_pc and go to PEND; pc holds until then.
  - ihit & !stall: instr_valid=1; pc <= pc+4; fetch_count increments.
  - ihit & stall: instr_valid=0; pc holds, and the next cycle re-fetches the same address.
  - !ihit: hold, instr_valid=0.
- PEND transitions:
  - halt: go to HALTED.
  - New redirect_en: overwrites pend_pc (youngest target wins).
  - On ihit: discard the returned instruction (instr_valid=0); pc <= pend_pc (or the concurrent redirect_pc if redirect_en is also high); return to FETCH.
  - Otherwise hold.
  - instr_valid is never 1 in PEND.
- HALTED: all inputs ignored; imemREN=0, instr_valid=0, halted=1. pc and fetch_count are frozen. Only RST exits.
- Zero-latency paths:
  - instr_valid is combinational from the state and the current ihit/stall/redirect_en/halt.
  - pc and the counter update on the same edge.
- Counter: fetch_count increments only when instr_valid=1. It holds at 2^CNT_W-1.
- Reset mid-miss or in PEND: pending redirect is discarded; the sequencer restarts at PC_INIT.

Test Plan:
- Reset then ihit=1 and stall=0 for 4 cycles → imemaddr 0x0, 0x4, 0x8, 0xC; instr_valid=1 every cycle; fetch_count=4; pc_plus4 tracks imemaddr+4.
- pc=0x10, ihit low for 3 cycles then high → imemaddr stays 0x10 and instr_valid=0 for 3 cycles; on the 4th cycle instr_valid=1; next imemaddr is 0x14.
- pc=0x20, ihit=1, stall=1 for 2 cycles then 0 → imemaddr 0x20 for 3 cycles; instr_valid only on the 3rd; fetch_count increments by 1.
- pc=0x30, ihit=1, redirect_en=1, redirect_pc=0x103 → instr_valid=0; next imemaddr=0x100.
- pc=0x40, ihit=0 with redirect 0x200, next cycle redirect 0x300 (ihit=0), then ihit=1 → state PEND; instr_valid=0 on the ihit cycle; next imemaddr=0x300.
- pc=0xFFFFFFFC accepted → next imemaddr=0x0. Then halt=1 with redirect_en=1 → halted=1, imemREN=0, imemaddr frozen at 0x0 for 5 cycles. RST=1 → imemaddr=PC_INIT, halted=0, fetch_count=0.
